// File: rtl/tdm_demux_1x4.sv
// Purpose: receive side of a 4-slot TDM link; reassembles slots 0..3 into four channel registers.
// Latency: channel outputs and frame_valid update one cycle after the slot-3 beat.
// Backpressure: none; a beat is accepted on every din_valid cycle, and idle gaps simply hold state.
module tdm_demux_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       slot;
    logic [1:0]       slot_nxt;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;
    logic [WIDTH-1:0] shadow0_nxt;
    logic [WIDTH-1:0] shadow1_nxt;
    logic [WIDTH-1:0] shadow2_nxt;
    logic             load_frame;
    logic             err_nxt;

    // Next-state decode: slot sequencing, shadow capture, frame commit and framing errors.
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        shadow0_nxt = shadow0;
        shadow1_nxt = shadow1;
        shadow2_nxt = shadow2;
        load_frame  = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            HUNT: begin
                // Non-sof beats are ignored silently while searching for alignment.
                if (din_valid && sof) begin
                    shadow0_nxt = din;
                    slot_nxt    = 2'd1;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (din_valid) begin
                    if (slot == 2'd0) begin
                        if (sof) begin
                            shadow0_nxt = din;
                            slot_nxt    = 2'd1;
                        end else begin
                            // Expected a frame start but got a mid-frame beat: alignment lost.
                            err_nxt   = 1'b1;
                            state_nxt = HUNT;
                            slot_nxt  = 2'd0;
                        end
                    end else if (sof) begin
                        // Early sof: drop the partial frame and restart on this beat.
                        err_nxt     = 1'b1;
                        shadow0_nxt = din;
                        slot_nxt    = 2'd1;
                    end else begin
                        case (slot)
                            2'd1: begin
                                shadow1_nxt = din;
                                slot_nxt    = 2'd2;
                            end
                            2'd2: begin
                                shadow2_nxt = din;
                                slot_nxt    = 2'd3;
                            end
                            default: begin
                                // Slot 3 completes the frame; slot 3 data goes straight to ch3.
                                load_frame = 1'b1;
                                slot_nxt   = 2'd0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                slot_nxt  = 2'd0;
            end
        endcase
    end

    // State, slot counter and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            slot    <= 2'd0;
            shadow0 <= '0;
            shadow1 <= '0;
            shadow2 <= '0;
        end else begin
            state   <= state_nxt;
            slot    <= slot_nxt;
            shadow0 <= shadow0_nxt;
            shadow1 <= shadow1_nxt;
            shadow2 <= shadow2_nxt;
        end
    end

    // Channel outputs commit all four slots together so they are never partially updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch0 <= '0;
            ch1 <= '0;
            ch2 <= '0;
            ch3 <= '0;
        end else if (load_frame) begin
            ch0 <= shadow0;
            ch1 <= shadow1;
            ch2 <= shadow2;
            ch3 <= din;
        end
    end

    // Registered status pulses; the decode never raises both in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= load_frame;
            sync_err    <= err_nxt;
        end
    end

    assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4 (WIDTH=8): directed frame scenarios then random traffic.
// Every cycle all outputs are compared with a queue-based frame model.
// Outputs are sampled 1 time unit after the rising edge.
module tb_tdm_demux_1x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic       frame_valid, sync_err, locked;

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is a queue of collected beats.
    logic [7:0] m_frame[$];
    logic [7:0] m_ch[4];
    logic       m_locked;
    logic       m_fv;
    logic       m_se;

    tdm_demux_1x4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_fv = 1'b0;
        m_se = 1'b0;
        if (rst) begin
            m_frame.delete();
            m_locked = 1'b0;
            for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
        end else if (din_valid) begin
            if (!m_locked) begin
                if (sof) begin
                    m_frame.delete();
                    m_frame.push_back(din);
                    m_locked = 1'b1;
                end
            end else if (m_frame.size() == 0) begin
                if (sof) m_frame.push_back(din);
                else begin
                    m_se = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (sof) begin
                m_se = 1'b1;
                m_frame.delete();
                m_frame.push_back(din);
            end else begin
                m_frame.push_back(din);
                if (m_frame.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_ch[i] = m_frame[i];
                    m_fv = 1'b1;
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ch0", ch0, m_ch[0]);
        chk("ch1", ch1, m_ch[1]);
        chk("ch2", ch2, m_ch[2]);
        chk("ch3", ch3, m_ch[3]);
        chk("frame_valid", {7'b0, frame_valid}, {7'b0, m_fv});
        chk("sync_err", {7'b0, sync_err}, {7'b0, m_se});
        chk("locked", {7'b0, locked}, {7'b0, m_locked});
    endtask

    task automatic beat(input logic [7:0] d, input logic s);
        rst = 1'b0; din_valid = 1'b1; din = d; sof = s;
        cycle();
    endtask

    task automatic idle();
        rst = 1'b0; din_valid = 1'b0; din = 8'hFF; sof = 1'b1;
        cycle();
    endtask

    task automatic reset_cycle();
        rst = 1'b1; din_valid = 1'($urandom); din = 8'($urandom); sof = 1'($urandom);
        cycle();
    endtask

    initial begin
        m_locked = 1'b0;
        m_fv = 1'b0;
        m_se = 1'b0;
        for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;

        // 1: reset with random inputs
        reset_cycle();
        reset_cycle();
        chk("t1_locked", {7'b0, locked}, 8'h00);
        chk("t1_ch3", ch3, 8'h00);

        // 2: back-to-back frame
        beat(8'hA1, 1'b1);
        beat(8'hB2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hD4, 1'b0);
        chk("t2_ch0", ch0, 8'hA1);
        chk("t2_ch1", ch1, 8'hB2);
        chk("t2_ch2", ch2, 8'hC3);
        chk("t2_ch3", ch3, 8'hD4);
        chk("t2_fv", {7'b0, frame_valid}, 8'h01);
        idle();
        chk("t2_fv_pulse", {7'b0, frame_valid}, 8'h00);

        // 3: same frame with gaps (idle cycles drive sof=1, din=FF)
        beat(8'hA1, 1'b1); idle(); idle(); idle();
        beat(8'hB2, 1'b0); idle(); idle(); idle();
        beat(8'hC3, 1'b0); idle(); idle(); idle();
        beat(8'hD4, 1'b0);
        chk("t3_fv", {7'b0, frame_valid}, 8'h01);
        chk("t3_ch3", ch3, 8'hD4);

        // 4: early sof
        beat(8'h11, 1'b1);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b1);
        chk("t4_se", {7'b0, sync_err}, 8'h01);
        beat(8'h44, 1'b0);
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        chk("t4_ch0", ch0, 8'h33);
        chk("t4_ch3", ch3, 8'h66);

        // 5: loss of alignment and relock
        beat(8'h77, 1'b0);
        chk("t5_se", {7'b0, sync_err}, 8'h01);
        chk("t5_locked", {7'b0, locked}, 8'h00);
        beat(8'h78, 1'b0);
        beat(8'h79, 1'b0);
        beat(8'h80, 1'b1);
        chk("t5_relock", {7'b0, locked}, 8'h01);

        // 6: reset mid-frame discards the partial frame
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        reset_cycle();
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk("t6_locked", {7'b0, locked}, 8'h00);
        chk("t6_ch0", ch0, 8'h00);

        // Random traffic: mostly aligned frames with occasional gaps, stray sof and reset
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) reset_cycle();
            else if (r < 25) idle();
            else if (r < 35) beat(8'($urandom), 1'($urandom));
            else begin
                // sof on the model's slot-0 position keeps frames flowing
                beat(8'($urandom), (m_frame.size() == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
